// File: rtl/restock_loader_if.sv
// Restock request handshake between a requester and the restock loader.
// The requester drives valid/product/qty; the loader answers with ready.
interface restock_loader_if #(
    parameter int QTY_W = 4
);
    logic             req_valid;
    logic [1:0]       req_product;
    logic [QTY_W-1:0] req_qty;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_product,
        output req_qty,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_product,
        input  req_qty,
        output req_ready
    );
endinterface

// File: rtl/restock_loader.sv
// Restock loader: accepts a restock request, then adds units one at a time
// to the inventory through a single-cycle inc strobe, re-reading the stock
// before every unit so it never pushes a product above MAX_STOCK.
// Optional lifetime unit counter enabled with macro RESTOCK_AUDIT_EN;
// without it total_loaded reads as zero.
module restock_loader #(
    parameter int MAX_STOCK = 10,
    parameter int QTY_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    restock_loader_if.slave  req,
    input  logic [QTY_W-1:0] stock_in,
    output logic [1:0]       inc_product,
    output logic             inc,
    output logic             busy,
    output logic             done,
    output logic [QTY_W-1:0] loaded,
    output logic             clipped,
    output logic [7:0]       total_loaded
);

    localparam logic [QTY_W-1:0] MAX_Q = QTY_W'(MAX_STOCK);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        PULSE,
        DONE
    } state_t;

    state_t           state;
    logic [QTY_W-1:0] remaining;

    // Request sequencing; every output is a register set on the edge that enters its state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            req.req_ready <= 1'b0;
            inc_product   <= 2'd0;
            inc           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            loaded        <= '0;
            clipped       <= 1'b0;
            remaining     <= '0;
        end else begin
            inc  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid && req.req_ready) begin
                        inc_product   <= req.req_product;
                        remaining     <= req.req_qty;
                        loaded        <= '0;
                        clipped       <= 1'b0;
                        req.req_ready <= 1'b0;
                        if (req.req_qty == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= CHECK;
                            busy  <= 1'b1;
                        end
                    end else begin
                        req.req_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    if (remaining == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (stock_in >= MAX_Q) begin
                        clipped <= 1'b1;
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state <= PULSE;
                        inc   <= 1'b1;
                    end
                end
                PULSE: begin
                    remaining <= remaining - QTY_W'(1);
                    loaded    <= loaded + QTY_W'(1);
                    state     <= CHECK;
                end
                DONE: begin
                    state         <= IDLE;
                    req.req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RESTOCK_AUDIT_EN
    // Lifetime count of units added, one per inc strobe, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_loaded <= 8'd0;
        end else if (inc && (total_loaded != 8'hFF)) begin
            total_loaded <= total_loaded + 8'd1;
        end
    end
`else
    assign total_loaded = 8'd0;
`endif

endmodule

// File: tb/tb_restock_loader.sv
// Directed testbench for restock_loader with a small inventory model that
// answers stock_in for the product being incremented and counts inc strobes.
module tb_restock_loader;

    localparam int QTY_W = 4;

    logic             clk;
    logic             rst;
    logic [QTY_W-1:0] stock_in;
    logic [1:0]       inc_product;
    logic             inc;
    logic             busy;
    logic             done;
    logic [QTY_W-1:0] loaded;
    logic             clipped;
    logic [7:0]       total_loaded;

    logic             preset_en;
    logic [1:0]       preset_idx;
    logic [QTY_W-1:0] preset_val;
    logic [QTY_W-1:0] stock [4];

    int check_count;
    int pass_count;
    int fail_count;

    int n_inc;
    int done_k;
    int gap_err;
    int side_err;
    int exp_total;

    restock_loader_if #(.QTY_W(QTY_W)) lif ();

    restock_loader #(.MAX_STOCK(10), .QTY_W(QTY_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (lif.slave),
        .stock_in     (stock_in),
        .inc_product  (inc_product),
        .inc          (inc),
        .busy         (busy),
        .done         (done),
        .loaded       (loaded),
        .clipped      (clipped),
        .total_loaded (total_loaded)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inventory model: preset by the bench, incremented by each inc strobe
    always @(posedge clk) begin
        if (preset_en) begin
            stock[preset_idx] <= preset_val;
        end else if (inc) begin
            stock[inc_product] <= stock[inc_product] + 4'd1;
        end
    end

    assign stock_in = stock[inc_product];

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic preset_stock(input logic [1:0] idx, input logic [QTY_W-1:0] val);
        preset_en  = 1'b1;
        preset_idx = idx;
        preset_val = val;
        @(posedge clk); #1;
        preset_en  = 1'b0;
    endtask

    // Issue one request from an idle loader and follow it to its done pulse.
    // k counts clock edges after the accepting edge; sampling is 1 unit after each edge.
    task automatic apply_stimulus(input logic [1:0] p, input logic [QTY_W-1:0] q, input logic hold_valid,
                                  output int incs, output int dk, output int gaps, output int side);
        int last_inc;
        incs     = 0;
        dk       = -1;
        gaps     = 0;
        side     = 0;
        last_inc = -10;
        if (lif.req_ready !== 1'b1) side++;
        lif.req_valid   = 1'b1;
        lif.req_product = p;
        lif.req_qty     = q;
        @(posedge clk); #1;
        if (hold_valid) begin
            lif.req_product = ~p;
            lif.req_qty     = 4'd9;
        end else begin
            lif.req_valid = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            if (inc_product !== p) side++;
            if (inc === 1'b1) begin
                if (incs > 0 && (k - last_inc) != 2) gaps++;
                last_inc = k;
                incs++;
            end
            if (done === 1'b1) begin
                if (busy !== 1'b0 || lif.req_ready !== 1'b0 || inc !== 1'b0) side++;
                dk = k;
                break;
            end
            if (busy !== 1'b1 || lif.req_ready !== 1'b0) side++;
            @(posedge clk); #1;
        end
        lif.req_valid = 1'b0;
    endtask

    initial begin
        check_count     = 0;
        pass_count      = 0;
        fail_count      = 0;
        exp_total       = 0;
        preset_en       = 1'b0;
        preset_idx      = 2'd0;
        preset_val      = 4'd0;
        lif.req_valid   = 1'b0;
        lif.req_product = 2'd0;
        lif.req_qty     = 4'd0;
        rst             = 1'b0;

        // Reset held: loader quiet and not ready
        preset_stock(2'd0, 4'd0);
        preset_stock(2'd1, 4'd3);
        preset_stock(2'd2, 4'd8);
        preset_stock(2'd3, 4'd0);
        check_output("rst_ready",   32'(lif.req_ready), 32'd0);
        check_output("rst_inc",     32'(inc),           32'd0);
        check_output("rst_busy",    32'(busy),          32'd0);
        check_output("rst_done",    32'(done),          32'd0);
        check_output("rst_total",   32'(total_loaded),  32'd0);

        // Release mid-cycle; ready comes up on the first edge after
        rst = 1'b1;
        #1;
        check_output("rel_ready_pre", 32'(lif.req_ready), 32'd0);
        @(posedge clk); #1;
        check_output("rel_ready",   32'(lif.req_ready), 32'd1);
        check_output("rel_inc",     32'(inc),           32'd0);
        check_output("rel_loaded",  32'(loaded),        32'd0);
        check_output("rel_clipped", 32'(clipped),       32'd0);

        // Product 1 at stock 3, qty 4, valid kept high to show it is ignored while busy
        apply_stimulus(2'd1, 4'd4, 1'b1, n_inc, done_k, gap_err, side_err);
        exp_total += 4;
        check_output("p1_incs",    32'(n_inc),    32'd4);
        check_output("p1_done_k",  32'(done_k),   32'd9);
        check_output("p1_gaps",    32'(gap_err),  32'd0);
        check_output("p1_side",    32'(side_err), 32'd0);
        check_output("p1_loaded",  32'(loaded),   32'd4);
        check_output("p1_clipped", 32'(clipped),  32'd0);
        check_output("p1_stock",   32'(stock[1]), 32'd7);
        @(posedge clk); #1;
        check_output("p1_idle_ready", 32'(lif.req_ready), 32'd1);
        check_output("p1_idle_done",  32'(done),          32'd0);
        @(posedge clk); #1;
        check_output("p1_hold_loaded", 32'(loaded), 32'd4);
`ifdef RESTOCK_AUDIT_EN
        check_output("p1_total", 32'(total_loaded), 32'd4);
`else
        check_output("p1_total", 32'(total_loaded), 32'd0);
`endif

        // Product 2 at stock 8, qty 5: clipped after two units at ceiling 10
        apply_stimulus(2'd2, 4'd5, 1'b0, n_inc, done_k, gap_err, side_err);
        exp_total += 2;
        check_output("p2_incs",    32'(n_inc),    32'd2);
        check_output("p2_done_k",  32'(done_k),   32'd5);
        check_output("p2_side",    32'(side_err), 32'd0);
        check_output("p2_loaded",  32'(loaded),   32'd2);
        check_output("p2_clipped", 32'(clipped),  32'd1);
        check_output("p2_stock",   32'(stock[2]), 32'd10);
        @(posedge clk); #1;
        check_output("p2_hold_clipped", 32'(clipped), 32'd1);

        // Zero quantity: done right after acceptance, clears previous loaded/clipped
        apply_stimulus(2'd3, 4'd0, 1'b0, n_inc, done_k, gap_err, side_err);
        check_output("q0_incs",    32'(n_inc),    32'd0);
        check_output("q0_done_k",  32'(done_k),   32'd0);
        check_output("q0_side",    32'(side_err), 32'd0);
        check_output("q0_loaded",  32'(loaded),   32'd0);
        check_output("q0_clipped", 32'(clipped),  32'd0);
        check_output("q0_stock",   32'(stock[3]), 32'd0);
        @(posedge clk); #1;

        // Product 0 at stock 0, qty 3: brings the lifetime total to 4+2+3
        apply_stimulus(2'd0, 4'd3, 1'b0, n_inc, done_k, gap_err, side_err);
        exp_total += 3;
        check_output("p0_incs",   32'(n_inc),    32'd3);
        check_output("p0_done_k", 32'(done_k),   32'd7);
        check_output("p0_loaded", 32'(loaded),   32'd3);
        check_output("p0_stock",  32'(stock[0]), 32'd3);
`ifdef RESTOCK_AUDIT_EN
        check_output("audit_total", 32'(total_loaded), 32'(exp_total));
`else
        check_output("audit_total", 32'(total_loaded), 32'd0);
`endif
        @(posedge clk); #1;

        // Product 3, qty 6, reset asserted after the second inc has landed
        lif.req_valid   = 1'b1;
        lif.req_product = 2'd3;
        lif.req_qty     = 4'd6;
        @(posedge clk); #1;
        lif.req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_output("mid_busy",   32'(busy),     32'd1);
        check_output("mid_stock",  32'(stock[3]), 32'd2);
        rst = 1'b0;
        #1;
        check_output("mr_inc",      32'(inc),           32'd0);
        check_output("mr_busy",     32'(busy),          32'd0);
        check_output("mr_ready",    32'(lif.req_ready), 32'd0);
        check_output("mr_loaded",   32'(loaded),        32'd0);
        check_output("mr_product",  32'(inc_product),   32'd0);
        check_output("mr_total",    32'(total_loaded),  32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_output("mr_stock_kept", 32'(stock[3]), 32'd2);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_output("mr_after_ready", 32'(lif.req_ready), 32'd1);
        check_output("mr_after_inc",   32'(inc),           32'd0);
        check_output("mr_after_busy",  32'(busy),          32'd0);
        check_output("mr_after_stock", 32'(stock[3]),      32'd2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
